key_schedule_ctrl: RTL and testbench

Sequencer that drives the combinational NK-word key-expansion step to produce the full AES round-key schedule for AES-128/192/256. It accepts a cipher key with a start pulse and iterates the expansion step once per cycle, generating the Rcon sequence internally. It stores every schedule word in an internal word array. The cipher round controller then reads 128-bit round keys by index through a registered read port.

---
 rtl/key_schedule_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES key-schedule sequencer for AES-128/192/256.
// Starts from a cipher key and applies one NK-word expansion step per cycle
// until the whole schedule is held in a word array. Round keys are then read
// back, 128 bits at a time, through a registered read port.
module key_schedule_ctrl #(
  parameter int NK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              key_ready,
  input  logic              rd_en,
  input  logic [3:0]        rd_idx,
  output logic [127:0]      rk_out,
  output logic              rk_valid
);

  localparam int NR   = NK + 6;
  localparam int NW   = 4 * (NR + 1);
  localparam int ITER = (NW + NK - 1) / NK - 1;
  localparam int AW   = $clog2(NW);
  localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) general multiply (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // One NK-word expansion step: produces the next NK schedule words from the
  // previous NK words. Word 0 sits in the most significant 32 bits.
  function automatic logic [32*NK-1:0] expand_step(input logic [32*NK-1:0] cur,
                                                   input logic [31:0] rcon_word);
    logic [32*NK-1:0] res;
    logic [31:0]      prev;
    logic [31:0]      word;
    res  = '0;
    prev = cur[31:0];
    for (int j = 0; j < NK; j++) begin
      if (j == 0) begin
        word = cur[32*(NK-1-j) +: 32] ^ sub_word(rot_word(prev)) ^ rcon_word;
      end else if ((NK == 8) && (j == 4)) begin
        word = cur[32*(NK-1-j) +: 32] ^ sub_word(prev);
      end else begin
        word = cur[32*(NK-1-j) +: 32] ^ prev;
      end
      res[32*(NK-1-j) +: 32] = word;
      prev = word;
    end
    return res;
  endfunction

  state_t            state_r, state_s;
  logic              load_s, step_s;
  logic [32*NK-1:0]  cur_r, nxt_s;
  logic [7:0]        rcon_r;
  logic [3:0]        cnt_r;
  logic [7:0]        wbase_s;
  logic [7:0]        rbase_s;
  logic              rd_ok_s;
  logic [31:0]       mem_r [NW];

  assign nxt_s   = expand_step(cur_r, {rcon_r, 24'h000000});
  assign wbase_s = 8'(NK * (int'(cnt_r) + 1));
  assign rbase_s = {2'b00, rd_idx, 2'b00};
  assign rd_ok_s = rd_en & key_ready & (rd_idx <= 4'(NR));

  // Next-state logic: start loads from IDLE or READY, EXPAND runs ITER steps.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = EXPAND;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      EXPAND: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_s = READY;
        end else begin
          state_s = EXPAND;
        end
      end
      READY: begin
        if (start) begin
          state_s = EXPAND;
          load_s  = 1'b1;
        end else begin
          state_s = READY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, working words, Rcon sequence, iteration count and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      cur_r     <= '0;
      rcon_r    <= 8'h01;
      cnt_r     <= 4'd0;
    end else begin
      state_r   <= state_s;
      busy      <= (state_s == EXPAND);
      key_ready <= (state_s == READY);
      if (load_s) begin
        cur_r  <= key_in;
        rcon_r <= 8'h01;
        cnt_r  <= 4'd0;
      end else if (step_s) begin
        cur_r  <= nxt_s;
        rcon_r <= xtime(rcon_r);
        cnt_r  <= cnt_r + 4'd1;
      end
    end
  end

  // Schedule storage: key words on load, expanded words each step; words past NW are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_s) begin
        for (int j = 0; j < NK; j++) begin
          mem_r[j] <= key_in[32*(NK-1-j) +: 32];
        end
      end else if (step_s) begin
        for (int j = 0; j < NK; j++) begin
          if ((wbase_s + 8'(j)) < 8'(NW)) begin
            mem_r[AW'(wbase_s + 8'(j))] <= nxt_s[32*(NK-1-j) +: 32];
          end
        end
      end
    end
  end

  // Registered round-key read port; invalid requests return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_out   <= 128'd0;
    end else if (rd_ok_s) begin
      rk_valid <= 1'b1;
      rk_out   <= {mem_r[AW'(rbase_s)],         mem_r[AW'(rbase_s + 8'd1)],
                   mem_r[AW'(rbase_s + 8'd2)], mem_r[AW'(rbase_s + 8'd3)]};
    end else begin
      rk_valid <= 1'b0;
      rk_out   <= 128'd0;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: one instance each for NK=4, 6 and 8, driven
// with FIPS-197 keys; round keys checked from a vector table plus directed
// sequences for restart, busy-time reads and reset during expansion.
module tb_key_schedule_ctrl;

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K256B =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic                 clk;
  logic [2:0]           rst_v, start_v, rd_en_v;
  logic [2:0][255:0]    key_v;
  logic [2:0][3:0]      idx_v;
  wire  [2:0]           busy_v, kr_v, rv_v;
  wire  [2:0][127:0]    rk_v;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           d;
    logic [3:0]   idx;
    logic         v;
    logic [127:0] rk;
  } vec_t;

  vec_t tbl[13];

  key_schedule_ctrl #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .key_in(key_v[0][127:0]),
    .busy(busy_v[0]), .key_ready(kr_v[0]), .rd_en(rd_en_v[0]), .rd_idx(idx_v[0]),
    .rk_out(rk_v[0]), .rk_valid(rv_v[0]));

  key_schedule_ctrl #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .key_in(key_v[1][191:0]),
    .busy(busy_v[1]), .key_ready(kr_v[1]), .rd_en(rd_en_v[1]), .rd_idx(idx_v[1]),
    .rk_out(rk_v[1]), .rk_valid(rv_v[1]));

  key_schedule_ctrl #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .key_in(key_v[2]),
    .busy(busy_v[2]), .key_ready(kr_v[2]), .rd_en(rd_en_v[2]), .rd_idx(idx_v[2]),
    .rk_out(rk_v[2]), .rk_valid(rv_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp_v);
    end
  endtask

  // Pulse start for one edge; key_in is scrambled afterwards to prove it is not resampled.
  task automatic do_start(input int d, input logic [255:0] key);
    @(negedge clk);
    start_v[d] = 1'b1;
    key_v[d]   = key;
    @(negedge clk);
    start_v[d] = 1'b0;
    key_v[d]   = ~key;
  endtask

  // Count edges (from start) until key_ready, and cycles seen with busy=1.
  task automatic wait_ready(input int d, input int edges0, input int exp_edges, input string name);
    int edges;
    int busy_cnt;
    edges    = edges0;
    busy_cnt = 0;
    while ((kr_v[d] !== 1'b1) && (edges < 64)) begin
      if (busy_v[d] === 1'b1) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    check_vec({name, ".latency"}, 128'(edges), 128'(exp_edges));
    check_vec({name, ".busy_cycles"}, 128'(busy_cnt), 128'(exp_edges - edges0));
    check_bit({name, ".busy_low"}, busy_v[d], 1'b0);
  endtask

  task automatic do_read(input int d, input logic [3:0] idx, input logic exp_v,
                         input logic [127:0] exp_rk, input string name);
    @(negedge clk);
    rd_en_v[d] = 1'b1;
    idx_v[d]   = idx;
    @(negedge clk);
    rd_en_v[d] = 1'b0;
    check_bit({name, ".valid"}, rv_v[d], exp_v);
    check_vec({name, ".rk"}, rk_v[d], exp_rk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[1]  = '{0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2]  = '{0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[3]  = '{0, 4'd11, 1'b0, 128'h0};
    tbl[4]  = '{1, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    tbl[5]  = '{1, 4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    tbl[6]  = '{1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
    tbl[7]  = '{1, 4'd13, 1'b0, 128'h0};
    tbl[8]  = '{2, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
    tbl[9]  = '{2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
    tbl[10] = '{2, 4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde};
    tbl[11] = '{2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
    tbl[12] = '{2, 4'd15, 1'b0, 128'h0};

    rst_v   = 3'b111;
    start_v = 3'b000;
    rd_en_v = 3'b000;
    idx_v   = '0;
    key_v   = '0;
    repeat (2) @(negedge clk);
    rst_v = 3'b000;

    // reset state of all three instances
    for (int d = 0; d < 3; d++) begin
      check_bit($sformatf("reset%0d.busy", d), busy_v[d], 1'b0);
      check_bit($sformatf("reset%0d.key_ready", d), kr_v[d], 1'b0);
      check_bit($sformatf("reset%0d.rk_valid", d), rv_v[d], 1'b0);
      check_vec($sformatf("reset%0d.rk_out", d), rk_v[d], 128'h0);
    end

    // read before any schedule exists
    do_read(0, 4'd0, 1'b0, 128'h0, "early_read");

    do_start(0, K128);
    check_bit("nk4.busy_after_start", busy_v[0], 1'b1);
    wait_ready(0, 1, 11, "nk4");

    do_start(1, K192);
    wait_ready(1, 1, 9, "nk6");

    // NK=8: start and read during EXPAND must be ignored
    do_start(2, K256);
    start_v[2] = 1'b1;
    key_v[2]   = K256B;
    rd_en_v[2] = 1'b1;
    idx_v[2]   = 4'd0;
    @(negedge clk);
    start_v[2] = 1'b0;
    rd_en_v[2] = 1'b0;
    check_bit("busy_read.valid", rv_v[2], 1'b0);
    check_vec("busy_read.rk", rk_v[2], 128'h0);
    check_bit("busy_start.busy", busy_v[2], 1'b1);
    wait_ready(2, 2, 8, "nk8");

    for (int i = 0; i < 13; i++) begin
      do_read(tbl[i].d, tbl[i].idx, tbl[i].v, tbl[i].rk, $sformatf("vec%0d", i));
    end

    // restart in READY together with a read: read uses the old schedule
    @(negedge clk);
    start_v[2] = 1'b1;
    key_v[2]   = K256B;
    rd_en_v[2] = 1'b1;
    idx_v[2]   = 4'd1;
    @(negedge clk);
    start_v[2] = 1'b0;
    rd_en_v[2] = 1'b0;
    key_v[2]   = ~K256B;
    check_bit("restart.valid", rv_v[2], 1'b1);
    check_vec("restart.old_rk1", rk_v[2], 128'h1f352c073b6108d72d9810a30914dff4);
    check_bit("restart.key_ready", kr_v[2], 1'b0);
    check_bit("restart.busy", busy_v[2], 1'b1);
    wait_ready(2, 1, 8, "restart");
    do_read(2, 4'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, "restart.rk0");
    do_read(2, 4'd1, 1'b1, 128'h101112131415161718191a1b1c1d1e1f, "restart.rk1");

    // reset during expansion
    do_start(2, K256);
    repeat (2) @(negedge clk);
    rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    check_bit("midrst.busy", busy_v[2], 1'b0);
    check_bit("midrst.key_ready", kr_v[2], 1'b0);
    repeat (12) @(negedge clk);
    check_bit("midrst.key_ready_stays", kr_v[2], 1'b0);
    do_read(2, 4'd2, 1'b0, 128'h0, "midrst.read");

    do_start(2, K256);
    wait_ready(2, 1, 8, "rerun");
    do_read(2, 4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde, "rerun.rk2");
    do_read(2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "rerun.rk14");

    // NK=4 schedule untouched by the other instances' activity
    do_read(0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "nk4.hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
